// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: fetch queue entry, fetch FSM states and
// the default reset fetch address.
package rv32i_types;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    FULL   = 2'd2,
    SQUASH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input and the
// valid/ready instruction queue towards decode.
interface instruction_fetch_if #(
  parameter int QUEUE_DEPTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic          imem_read;
  logic [31:0]   imem_address;
  logic          imem_resp;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          iq_valid;
  logic          iq_ready;
  logic [31:0]   iq_instr;
  logic [31:0]   iq_pc;
  logic [CW-1:0] iq_count;

  modport master (
    output imem_read, imem_address, iq_valid, iq_instr, iq_pc, iq_count,
    input  imem_resp, imem_rdata, redirect, redirect_pc, iq_ready
  );

  modport slave (
    input  imem_read, imem_address, iq_valid, iq_instr, iq_pc, iq_count,
    output imem_resp, imem_rdata, redirect, redirect_pc, iq_ready
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// In-order FIFO of fetched {pc, instr} entries; flush beats push and pop.
module fetch_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic [CW-1:0] count_q;

  // Storage is reset so the decode outputs read as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= tail_ptr + 1'b1;
      end
      if (pop) head_ptr <= head_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[head_ptr];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, single-outstanding imem read FSM and decode queue.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module instruction_fetch
  import rv32i_types::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t  state, state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   squash_addr;
  logic          read_en;
  logic          push;
  logic          pop;
  logic          bypass_hit;
  logic          bypass_take;
  logic [CW-1:0] count_after;
  fetch_entry_t  q_head;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({fetch_pc, bus.imem_rdata}),
    .pop       (pop),
    .flush     (bus.redirect),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = (state == FETCH) && bus.imem_resp && !bus.redirect && q_empty;
  assign bus.iq_valid = !q_empty || bypass_hit;
  assign bus.iq_instr = bypass_hit ? bus.imem_rdata : q_head.instr;
  assign bus.iq_pc    = bypass_hit ? fetch_pc : q_head.pc;
`else
  assign bypass_hit   = 1'b0;
  assign bus.iq_valid = !q_empty;
  assign bus.iq_instr = q_head.instr;
  assign bus.iq_pc    = q_head.pc;
`endif

  assign bypass_take = bypass_hit && bus.iq_ready;
  assign pop         = bus.iq_ready && !q_empty && !bus.redirect;
  assign count_after = q_count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    read_en    = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        read_en = !q_full;
        if (bus.redirect) begin
          state_next = bus.imem_resp ? FETCH : SQUASH;
        end else if (bus.imem_resp) begin
          push = !bypass_take;
          if (count_after == CW'(QUEUE_DEPTH)) state_next = FULL;
        end
      end
      FULL: begin
        if (bus.redirect || pop) state_next = FETCH;
      end
      SQUASH: begin
        read_en = 1'b1;
        if (bus.imem_resp) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  // squash_addr holds the abandoned request's address until its response drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      squash_addr <= RESET_PC;
    end else begin
      if (bus.redirect)
        fetch_pc <= bus.redirect_pc;
      else if (state == FETCH && bus.imem_resp)
        fetch_pc <= fetch_pc + 32'd4;
      if (state == FETCH && bus.redirect && !bus.imem_resp)
        squash_addr <= fetch_pc;
    end
  end

  assign bus.imem_read    = read_en;
  assign bus.imem_address = (state == SQUASH) ? squash_addr : fetch_pc;
  assign bus.iq_count     = q_count;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that directly feeds the instruction register/decode stage. It owns the fetch PC and issues one instruction-memory read at a time under the held-until-response memory protocol. Returned words are buffered with their PCs in a small in-order queue, which decode drains through a valid/ready handshake. A redirect (branch/jump resolution or mispredict recovery) flushes the queue and restarts fetch at a new PC, discarding any in-flight response.

## Interface
Parameters:
- QUEUE_DEPTH, 4, number of queue entries; power of two, at least 2
- RESET_PC, 32'h0000_0060, first fetch address after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- imem_read  out  1  read request; held high until imem_resp
- imem_address  out  32  fetch address; stable while imem_read is high
- imem_resp  in  1  one-cycle pulse: read complete, imem_rdata valid
- imem_rdata  in  32  instruction word
- redirect  in  1  one-cycle pulse: flush and restart fetch
- redirect_pc  in  32  new fetch PC; sampled when redirect=1
- iq_valid  out  1  head entry available to decode
- iq_ready  in  1  decode accepts head; pop when iq_valid && iq_ready
- iq_instr  out  32  head instruction; feeds the instruction register `in` port
- iq_pc  out  32  PC of head instruction
- iq_count  out  $clog2(QUEUE_DEPTH)+1  occupied entries

## Operation
- States: IDLE, FETCH, FULL, SQUASH.
- IDLE: entered only on reset. Moves to FETCH on the first clock after rst deasserts.
- FETCH:
  - imem_read=1, imem_address=fetch_pc.
  - On imem_resp without redirect: push {fetch_pc, imem_rdata}; fetch_pc += 4 (mod 2^32, wraps). Stay in FETCH if post-update count < QUEUE_DEPTH, else go to FULL.
- FULL: imem_read=0. Return to FETCH on the cycle after any pop.
- SQUASH: a response is still owed for a discarded request. Keep imem_read=1 with the old address. On imem_resp, drop the data and go to FETCH.
- Redirect handling:
  - Every redirect clears the queue (count=0) and sets fetch_pc=redirect_pc.
  - A pop in the same cycle as a redirect is ignored.
  - In FETCH with imem_resp in the same cycle: drop the response and go to FETCH.
  - In FETCH without imem_resp: go to SQUASH.
  - In FULL or SQUASH: go to FETCH from FULL; stay in SQUASH from SQUASH (fetch_pc updated).
- Push and pop in the same cycle leave count unchanged.
- A push always has space: at most one read is outstanding, and reads are issued only when count < QUEUE_DEPTH.
- Queue order is strict FIFO. Head/tail pointers are log2(QUEUE_DEPTH) bits and wrap naturally.

## Timing
- Reset values: imem_read=0, imem_address=RESET_PC, iq_valid=0, iq_instr=0, iq_pc=0, iq_count=0, state=IDLE, fetch_pc=RESET_PC.
- First imem_read=1 appears on the cycle after rst deasserts.
- Response-to-decode latency: 1 cycle without bypass (entry is visible the cycle after imem_resp); 0 cycles with bypass (see Configuration).
- After a pop, the next head is visible on the following cycle.
- Redirect: iq_valid=0 the cycle after redirect. imem_address=redirect_pc the cycle after redirect, unless the state is SQUASH.
- Reset asserted mid-read: all state clears immediately. The outstanding response is not tracked, and the memory side is reset together with this block.

## Configuration
- FETCH_BYPASS_EN defined:
  - When the queue is empty and imem_resp arrives without redirect, iq_valid=1, iq_instr=imem_rdata, iq_pc=fetch_pc combinationally in that same cycle.
  - If iq_ready is also 1, the entry is consumed and not written to the queue.
  - iq_count excludes the bypassed entry.
- FETCH_BYPASS_EN undefined: all outputs to decode come from registered queue storage. No combinational path from imem_* to iq_*.

## Structure
- Shared package rv32i_types gains:
  - fetch_entry_t, a packed struct of {pc[31:0], instr[31:0]}
  - fetch_state_t enum {IDLE, FETCH, FULL, SQUASH}
  - the default RESET_PC constant
- One sub-module, fetch_queue: a parameterised FIFO of fetch_entry_t with push, pop, flush, count, full and empty. Flush takes priority over push and pop.
- FSM, PC register and bypass mux live in instruction_fetch.

## Test plan
- Reset then iq_ready=1, with memory answering each read 2 cycles after request:
  - imem_address sequence 0x60, 0x64, 0x68.
  - iq_pc sequence matches, each with the correct instruction word.
- iq_ready=0, DEPTH=4: after 4 responses, iq_count=4, state FULL, imem_read=0. One pop causes imem_read=1 at 0x70 on the next cycle.
- Redirect to 0x200 while a read to 0x68 is outstanding:
  - queue clears; the next response (0x68 data) is dropped.
  - imem_address=0x200 follows; first iq_pc=0x200.
- Redirect in the same cycle as imem_resp: data dropped, no SQUASH, next address is redirect_pc.
- fetch_pc=0xFFFF_FFFC: after its response, the next imem_address is 0x0000_0000.
- Bypass build: empty queue, imem_resp with iq_ready=1 gives iq_valid=1 in the same cycle and iq_count stays 0. In a non-bypass build, iq_valid rises one cycle later.
